stage5_write_back: RTL and testbench
====================================

Name: stage5_write_back

Overview:
- MEM/WB pipeline register plus write-back logic; sits directly downstream of the memory-access stage.
- Captures the ALU result, the load data returned by data memory, and the destination/control bits.
- Selects the write-back value and drives the register-file write port.
- Provides forwarding taps and a retired-instruction counter.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
DATA_WIDTH, 64 (`LEGV8_INTEGER_SZ), width of the datapath
REG_ADDR_WIDTH, 5, register index width
ZERO_REG, 31, index of XZR; writes to it are suppressed
CNT_WIDTH, 32, retired-instruction counter width

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  memory stage holds a real instruction this cycle
stall  input  1  hold the MEM/WB register contents
flush  input  1  load a bubble instead of the incoming instruction
alu_result  input  DATA_WIDTH  address/ALU value from the memory stage
mem_data  input  DATA_WIDTH  data-memory read data (may be high-Z when not reading)
rd  input  REG_ADDR_WIDTH  destination register
regwrite  input  1  instruction writes a register
memtoreg  input  1  write-back value comes from memory
wb_valid  output  1  MEM/WB holds a valid instruction
rf_we  output  1  register-file write enable
rf_waddr  output  REG_ADDR_WIDTH  register-file write index
rf_wdata  output  DATA_WIDTH  register-file write data
fwd_en  output  1  forwarding tap valid (= wb_valid & regwrite_q & rd_q!=ZERO_REG)
retired_count  output  CNT_WIDTH  instructions retired since reset

Behaviour:
- Reset (async, active-high): valid_q, regwrite_q, memtoreg_q, rd_q, alu_q, mem_q, written_q and retired_count all clear to 0. Consequently every output is 0 during and after reset until the first capture.
- Register update on rising clk, priority flush > stall > capture:
  - flush=1: valid_q<=0, regwrite_q<=0; data fields don't-care (clear to 0).
  - stall=1 (flush=0): all fields hold.
  - otherwise: capture in_valid, alu_result, rd, regwrite, memtoreg. mem_q <= memtoreg ? mem_data : 0, so high-Z is never latched.
- Latency: one cycle from memory-stage inputs to rf_* outputs.
- rf_wdata = memtoreg_q ? mem_q : alu_q (combinational from registers).
- rf_waddr = rd_q.
- written_q tracks whether the current occupant has already been written:
  - Set to 1 at any edge where rf_we=1 and stall=1.
  - Cleared on any non-stall edge.
- rf_we = valid_q & regwrite_q & (rd_q != ZERO_REG) & ~written_q. A stalled instruction therefore writes exactly once, in its first WB cycle.
- fwd_en ignores written_q; forwarding stays available while the instruction is held.
- Retirement: at each edge with wb_valid=1 and stall=0, retired_count increments by 1, wrapping modulo 2^CNT_WIDTH.
  - A flush does not cancel the retirement of the current occupant; it only bubbles the incoming instruction.
  - Bubbles (valid_q=0) never count.
- Simultaneous stall+flush: flush wins; the current occupant retires if valid, and a bubble is loaded.
- Reset asserted mid-stall or mid-write: immediate clear. No partial write may follow reset release; rf_we stays 0 until the next valid capture.
- Writes to ZERO_REG: the instruction still counts as retired, but rf_we=0 and fwd_en=0.

Test Plan:
- Reset then ALU op: in_valid=1, regwrite=1, memtoreg=0, rd=5, alu_result=0x2A → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x2A; retired_count goes 0→1 on the following edge.
- Load: memtoreg=1, mem_data=0x7, alu_result=0x3, rd=9 → rf_wdata=0x7. Then an ALU op with mem_data=Z → mem_q=0, rf_wdata=alu_result, no X on outputs.
- Stall 3 cycles with a valid write to rd=4 → rf_we high for the first cycle only, fwd_en high for all 4 cycles, retired_count +1 total.
- XZR write: rd=31, regwrite=1 → rf_we=0, fwd_en=0, retired_count still +1.
- flush=1 and stall=1 together while WB holds a valid instruction → next cycle wb_valid=0, rf_we=0, retired_count +1. Then retired_count preset near 0xFFFFFFFF by 2 retirements → wraps to 0x00000001.
- Assert reset asynchronously mid-cycle with rf_we=1 → rf_we, wb_valid, rf_wdata and retired_count read 0 before the next clk edge.

Source files
------------

// File: rtl/stage5_write_back_if.sv
// stage5_write_back_if: memory-stage inputs and write-back outputs of the MEM/WB stage
interface stage5_write_back_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    logic                      in_valid;
    logic                      stall;
    logic                      flush;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     mem_data;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      regwrite;
    logic                      memtoreg;
    logic                      wb_valid;
    logic                      rf_we;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0]     rf_wdata;
    logic                      fwd_en;
    logic [CNT_WIDTH-1:0]      retired_count;

    modport master (
        output in_valid, stall, flush, alu_result, mem_data, rd, regwrite, memtoreg,
        input  wb_valid, rf_we, rf_waddr, rf_wdata, fwd_en, retired_count
    );

    modport slave (
        input  in_valid, stall, flush, alu_result, mem_data, rd, regwrite, memtoreg,
        output wb_valid, rf_we, rf_waddr, rf_wdata, fwd_en, retired_count
    );
endinterface

// File: rtl/stage5_write_back.sv
// stage5_write_back: MEM/WB pipeline register, write-back mux, forwarding tap and retire counter
module stage5_write_back #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ZERO_REG       = 31,
    parameter int CNT_WIDTH      = 32
) (
    input logic                clk,
    input logic                reset,
    stage5_write_back_if.slave bus
);
    localparam logic [REG_ADDR_WIDTH-1:0] ZR = REG_ADDR_WIDTH'(ZERO_REG);

    logic                      valid_q, regwrite_q, memtoreg_q, written_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]     alu_q, mem_q;
    logic [CNT_WIDTH-1:0]      cnt_q;
    logic                      hold, live, we;

    // flush overrides stall, so only a stall without flush really holds the occupant
    assign hold = bus.stall & ~bus.flush;
    assign live = valid_q & regwrite_q & (rd_q != ZR);
    assign we   = live & ~written_q;

    assign bus.wb_valid      = valid_q;
    assign bus.rf_we         = we;
    assign bus.rf_waddr      = rd_q;
    assign bus.rf_wdata      = memtoreg_q ? mem_q : alu_q;
    assign bus.fwd_en        = live;
    assign bus.retired_count = cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            written_q  <= 1'b0;
            rd_q       <= '0;
            alu_q      <= '0;
            mem_q      <= '0;
            cnt_q      <= '0;
        end else begin
            if (valid_q && !hold) cnt_q <= cnt_q + CNT_WIDTH'(1);
            written_q <= hold & (we | written_q);
            if (bus.flush) begin
                valid_q    <= 1'b0;
                regwrite_q <= 1'b0;
                memtoreg_q <= 1'b0;
                rd_q       <= '0;
                alu_q      <= '0;
                mem_q      <= '0;
            end else if (!bus.stall) begin
                valid_q    <= bus.in_valid;
                regwrite_q <= bus.regwrite;
                memtoreg_q <= bus.memtoreg;
                rd_q       <= bus.rd;
                alu_q      <= bus.alu_result;
                mem_q      <= bus.memtoreg ? bus.mem_data : '0;
            end
        end
    end
endmodule

// File: tb/tb_stage5_write_back.sv
// tb_stage5_write_back: vector table fed through a scoreboard, plus async-reset and counter-wrap sequences
module tb_stage5_write_back;
    logic clk;
    logic reset;

    typedef struct {
        logic        v, s, f, rw, mr, z;
        logic [4:0]  rd;
        logic [63:0] alu, mem;
        logic        e_v, e_we, e_fwd;
        logic [4:0]  e_wa;
        logic [63:0] e_wd;
        logic [31:0] e_cnt;
    } vec_t;

    typedef struct {
        logic        e_v, e_we, e_fwd;
        logic [4:0]  e_wa;
        logic [63:0] e_wd;
        logic [31:0] e_cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    stage5_write_back_if #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) bus ();
    stage5_write_back_if #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .CNT_WIDTH(2))  bus2 ();

    stage5_write_back #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .ZERO_REG(31), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    // a 2-bit counter copy sees identical traffic so wrap-around shows up within a few retirements
    stage5_write_back #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .ZERO_REG(31), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    assign bus2.in_valid   = bus.in_valid;
    assign bus2.stall      = bus.stall;
    assign bus2.flush      = bus.flush;
    assign bus2.alu_result = bus.alu_result;
    assign bus2.mem_data   = bus.mem_data;
    assign bus2.rd         = bus.rd;
    assign bus2.regwrite   = bus.regwrite;
    assign bus2.memtoreg   = bus.memtoreg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, logic s, logic f, logic [4:0] rd, logic rw, logic mr, logic z,
                                logic [63:0] alu, logic [63:0] mem, logic e_v, logic e_we, logic [4:0] e_wa,
                                logic [63:0] e_wd, logic e_fwd, logic [31:0] e_cnt);
        vec_t r;
        r.v = v; r.s = s; r.f = f; r.rd = rd; r.rw = rw; r.mr = mr; r.z = z; r.alu = alu; r.mem = mem;
        r.e_v = e_v; r.e_we = e_we; r.e_wa = e_wa; r.e_wd = e_wd; r.e_fwd = e_fwd; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t r);
        bus.in_valid   = r.v;
        bus.stall      = r.s;
        bus.flush      = r.f;
        bus.rd         = r.rd;
        bus.regwrite   = r.rw;
        bus.memtoreg   = r.mr;
        bus.alu_result = r.alu;
        bus.mem_data   = r.z ? {64{1'bz}} : r.mem;
    endtask

    task automatic apply(input vec_t r);
        exp_t e;
        logic [31:0] c;
        drive(r);
        sb.push_back('{r.e_v, r.e_we, r.e_fwd, r.e_wa, r.e_wd, r.e_cnt});
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        c = e.e_cnt;
        chk("wb_valid", 64'(bus.wb_valid), 64'(e.e_v));
        chk("rf_we", 64'(bus.rf_we), 64'(e.e_we));
        chk("rf_waddr", 64'(bus.rf_waddr), 64'(e.e_wa));
        chk("rf_wdata", bus.rf_wdata, e.e_wd);
        chk("fwd_en", 64'(bus.fwd_en), 64'(e.e_fwd));
        chk("retired_count", 64'(bus.retired_count), 64'(c));
        chk("retired_count_wrap", 64'(bus2.retired_count), 64'(c[1:0]));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wb_valid"}, 64'(bus.wb_valid), 64'd0);
        chk({tag, "_rf_we"}, 64'(bus.rf_we), 64'd0);
        chk({tag, "_rf_waddr"}, 64'(bus.rf_waddr), 64'd0);
        chk({tag, "_rf_wdata"}, bus.rf_wdata, 64'd0);
        chk({tag, "_fwd_en"}, 64'(bus.fwd_en), 64'd0);
        chk({tag, "_retired_count"}, 64'(bus.retired_count), 64'd0);
    endtask

    initial begin
        //            v  s  f  rd rw mr z  alu                      mem                      ev we wa wd                        fwd cnt
        vecs.push_back(mk(1, 0, 0, 5, 1, 0, 1, 64'h2A,                 64'h0,                   1, 1, 5, 64'h2A,                  1, 0));
        vecs.push_back(mk(1, 0, 0, 9, 1, 1, 0, 64'h3,                  64'h7,                   1, 1, 9, 64'h7,                   1, 1));
        vecs.push_back(mk(1, 0, 0, 10, 1, 0, 1, 64'h1234,              64'h0,                   1, 1, 10, 64'h1234,               1, 2));
        vecs.push_back(mk(1, 0, 0, 4, 1, 0, 0, 64'h44,                 64'h0,                   1, 1, 4, 64'h44,                  1, 3));
        vecs.push_back(mk(1, 1, 0, 7, 1, 0, 0, 64'h99,                 64'h0,                   1, 0, 4, 64'h44,                  1, 3));
        vecs.push_back(mk(1, 1, 0, 7, 1, 0, 0, 64'h99,                 64'h0,                   1, 0, 4, 64'h44,                  1, 3));
        vecs.push_back(mk(1, 1, 0, 7, 1, 0, 0, 64'h99,                 64'h0,                   1, 0, 4, 64'h44,                  1, 3));
        vecs.push_back(mk(1, 0, 0, 31, 1, 0, 0, 64'h55,                64'h0,                   1, 0, 31, 64'h55,                 0, 4));
        vecs.push_back(mk(0, 0, 0, 3, 1, 0, 0, 64'h66,                 64'h0,                   0, 0, 3, 64'h66,                  0, 5));
        vecs.push_back(mk(1, 0, 0, 12, 1, 0, 0, 64'h77,                64'h0,                   1, 1, 12, 64'h77,                 1, 5));
        vecs.push_back(mk(1, 1, 1, 13, 1, 0, 0, 64'h88,                64'h0,                   0, 0, 0, 64'h0,                   0, 6));
        vecs.push_back(mk(1, 0, 0, 14, 0, 0, 0, 64'hAB,                64'h0,                   1, 0, 14, 64'hAB,                 0, 6));
        vecs.push_back(mk(1, 0, 1, 15, 1, 0, 0, 64'hCD,                64'h0,                   0, 0, 0, 64'h0,                   0, 7));
        vecs.push_back(mk(1, 0, 0, 20, 1, 1, 0, 64'h5,                 64'hDEADBEEF00000001,    1, 1, 20, 64'hDEADBEEF00000001,   1, 7));
        vecs.push_back(mk(1, 1, 0, 22, 1, 1, 0, 64'h6,                 64'h123,                 1, 0, 20, 64'hDEADBEEF00000001,   1, 7));
        vecs.push_back(mk(1, 0, 0, 21, 1, 0, 1, 64'hFFFFFFFFFFFFFFFF,  64'h0,                   1, 1, 21, 64'hFFFFFFFFFFFFFFFF,   1, 8));

        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 0, 0, 0, 64'h0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // async reset while a write is being presented
        chk("pre_reset_rf_we", 64'(bus.rf_we), 64'd1);
        #1 reset = 1'b1;
        #1 chk_zero("async_reset");
        drive(mk(0, 0, 0, 6, 1, 0, 0, 64'h10, 64'h0, 0, 0, 0, 64'h0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        chk_zero("held_reset");
        reset = 1'b0;
        apply(mk(0, 0, 0, 6, 1, 0, 0, 64'h10, 64'h0, 0, 0, 6, 64'h10, 0, 0));
        apply(mk(1, 0, 0, 6, 1, 0, 0, 64'h10, 64'h0, 1, 1, 6, 64'h10, 1, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 0, 0, 0, 64'h0, 0, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
